// File: rtl/pll_lock_rst_seq.sv
// PLL reset sequencer and lock supervisor.
// Runs on the PLL reference clock, which keeps running while the PLL is unlocked.
// It pulses the PLL RESET, qualifies the synchronized lock, and releases the
// system reset only after lock has held steady. On a lock loss it re-acquires
// on its own. Repeated acquisition timeouts latch a sticky failure.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// RST_PLL   | PLL RESET asserted for PLL_RST_CYCLES cycles
// WAIT_LOCK | waiting for lock_s; the timeout counter is running
// STABLE    | lock_s high; counting consecutive stable cycles
// RUN       | locked and qualified; system reset released
// FAIL      | retries exhausted; everything held in reset until rst
module pll_lock_rst_seq #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       pll_ready,
  output logic       sys_rst,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic       lock_lost_pulse,
  output logic [7:0] lock_lost_cnt
);

  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);

  // The timeout is reached on the edge where the count would reach its limit.
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST    = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic             STB_ONE     = (LOCK_STABLE_CYCLES == 1);
  localparam logic [15:0]      RST_LEN     = 16'(PLL_RST_CYCLES);
  localparam logic [2:0]       RETRY_LAST  = 3'(MAX_RETRIES - 1);
  localparam logic [2:0]       RETRY_FINAL = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RST_PLL,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic               lock_m_q, lock_s_q;
  logic [15:0]        rcnt_q, rcnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [STB_W-1:0]   stb_q, stb_d;
  logic [2:0]         retry_q, retry_d;
  logic [7:0]         lost_q, lost_d;
  logic               pulse_q, pulse_d;
  logic               pll_rst_q, pll_rst_d;
  logic               ready_q, ready_d;
  logic               sys_rst_q, sys_rst_d;
  logic               fail_q, fail_d;
  logic               tmo_hit;
  logic               retry_req;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      lock_m_q <= pll_lock;
      lock_s_q <= lock_m_q;
    end
  end

  assign tmo_hit = (tmo_q == TMO_LAST);

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    tmo_d     = tmo_q;
    stb_d     = stb_q;
    retry_d   = retry_q;
    lost_d    = lost_q;
    pulse_d   = 1'b0;
    retry_req = 1'b0;

    case (state_q)
      ST_RST_PLL: begin
        // The counter starts at 1 on entry, so the entry cycle counts as
        // the first of the pulse; out of rst it starts at 0.
        if (rcnt_q == RST_LEN) begin
          state_d = ST_WAIT_LOCK;
          tmo_d   = '0;
          stb_d   = '0;
        end else begin
          rcnt_d = rcnt_q + 16'd1;
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_s_q && STB_ONE) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else if (tmo_hit) begin
          retry_req = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (lock_s_q) begin
            state_d = ST_STABLE;
            stb_d   = STB_W'(1);
          end
        end
      end

      ST_STABLE: begin
        // If stable completes on the timeout edge, that edge still goes to RUN.
        if (lock_s_q && (stb_q == STB_LAST)) begin
          state_d = ST_RUN;
          retry_d = '0;
          stb_d   = '0;
        end else if (tmo_hit) begin
          retry_req = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (lock_s_q) begin
            stb_d = stb_q + STB_W'(1);
          end else begin
            state_d = ST_WAIT_LOCK;
            stb_d   = '0;
          end
        end
      end

      ST_RUN: begin
        if (!lock_s_q) begin
          state_d = ST_RST_PLL;
          rcnt_d  = 16'd1;
          pulse_d = 1'b1;
          if (lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
          end
        end
      end

      ST_FAIL: begin
        state_d = ST_FAIL;
      end

      default: begin
        state_d = ST_RST_PLL;
        rcnt_d  = 16'd1;
      end
    endcase

    if (retry_req) begin
      stb_d = '0;
      if (retry_q == RETRY_LAST) begin
        state_d = ST_FAIL;
        retry_d = RETRY_FINAL;
      end else begin
        state_d = ST_RST_PLL;
        retry_d = retry_q + 3'd1;
        rcnt_d  = 16'd1;
      end
    end

    // Outputs follow the next state so that they change on the same edge as the state.
    pll_rst_d = (state_d == ST_RST_PLL) || (state_d == ST_FAIL);
    ready_d   = (state_d == ST_RUN);
    sys_rst_d = (state_d != ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RST_PLL;
      rcnt_q    <= '0;
      tmo_q     <= '0;
      stb_q     <= '0;
      retry_q   <= '0;
      lost_q    <= '0;
      pulse_q   <= 1'b0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      sys_rst_q <= 1'b1;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      tmo_q     <= tmo_d;
      stb_q     <= stb_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pulse_q   <= pulse_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      sys_rst_q <= sys_rst_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign pll_ready       = ready_q;
  assign sys_rst         = sys_rst_q;
  assign fail            = fail_q;
  assign retry_cnt       = retry_q;
  assign lock_lost_pulse = pulse_q;
  assign lock_lost_cnt   = lost_q;

endmodule
